// File: rtl/serializador.sv
// Parallel-in, serial-out transmitter: captures a WIDTH-bit word on inicio and
// shifts it out one bit per clock on saida, with load marking each valid bit.
module serializador #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dado,
   input  logic             inicio,
   output logic             saida,
   output logic             load,
   output logic             ocupado,
   output logic             pronto
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sr_next;
   logic             next_bit;
   logic             first_bit;

   // The bit already on saida sits at the outgoing end of sr; the next one is its neighbour.
   always_comb begin
      sr_next   = '0;
      next_bit  = 1'b0;
      first_bit = 1'b0;
      if (MSB_FIRST) begin
         sr_next   = {sr[WIDTH-2:0], 1'b0};
         next_bit  = sr[WIDTH-2];
         first_bit = dado[WIDTH-1];
      end else begin
         sr_next   = {1'b0, sr[WIDTH-1:1]};
         next_bit  = sr[1];
         first_bit = dado[0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         sr      <= '0;
         cnt     <= '0;
         saida   <= 1'b0;
         load    <= 1'b0;
         ocupado <= 1'b0;
         pronto  <= 1'b0;
      end else begin
         case (state)
            // The edge leaving DONE is the first idle edge, so a held inicio
            // restarts WIDTH+1 cycles after the previous accept.
            IDLE, DONE: begin
               pronto <= 1'b0;
               cnt    <= '0;
               if (inicio) begin
                  state   <= SHIFT;
                  sr      <= dado;
                  saida   <= first_bit;
                  load    <= 1'b1;
                  ocupado <= 1'b1;
               end else begin
                  state   <= IDLE;
                  saida   <= 1'b0;
                  load    <= 1'b0;
                  ocupado <= 1'b0;
               end
            end
            SHIFT: begin
               if (cnt == LAST) begin
                  state   <= DONE;
                  sr      <= '0;
                  cnt     <= '0;
                  saida   <= 1'b0;
                  load    <= 1'b0;
                  ocupado <= 1'b0;
                  pronto  <= 1'b1;
               end else begin
                  cnt   <= cnt + 1'b1;
                  sr    <= sr_next;
                  saida <= next_bit;
               end
            end
            default: begin
               state   <= IDLE;
               saida   <= 1'b0;
               load    <= 1'b0;
               ocupado <= 1'b0;
               pronto  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serializador.sv
// Bench for serializador: MSB-first and LSB-first instances share the inputs and
// are compared every cycle against a word/start-edge reference model.
module tb_serializador;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         inicio;
   logic [W-1:0] dado;
   logic         m_saida, m_load, m_ocupado, m_pronto;
   logic         l_saida, l_load, l_ocupado, l_pronto;

   int checks   = 0;
   int failures = 0;

   serializador #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .dado(dado), .inicio(inicio),
      .saida(m_saida), .load(m_load), .ocupado(m_ocupado), .pronto(m_pronto)
   );

   serializador #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset), .dado(dado), .inicio(inicio),
      .saida(l_saida), .load(l_load), .ocupado(l_ocupado), .pronto(l_pronto)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // A word accepted at edge n0 puts bit k out after edge n0+k, pronto after n0+W;
   // a new start is taken at any edge from n0+W+1 on.
   int           cyc = 0;
   int           n0  = -1;
   logic [W-1:0] w   = '0;

   always @(posedge clk) begin
      cyc++;
      if (reset) n0 = -1;
      else if (inicio && (n0 < 0 || cyc >= n0 + W + 1)) begin
         n0 = cyc;
         w  = dado;
      end
   end

   function automatic logic [7:0] expected();
      int k;
      k = cyc - n0;
      if (n0 >= 0 && k >= 0 && k < W) return {w[W-1-k], 3'b110, w[k], 3'b110};
      if (n0 >= 0 && k == W)          return 8'b0001_0001;
      return 8'h00;
   endfunction

   function automatic logic [7:0] observed();
      return {m_saida, m_load, m_ocupado, m_pronto, l_saida, l_load, l_ocupado, l_pronto};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] got;
      reset  = 1'b1;
      inicio = 1'b1;
      dado   = W'($urandom);
      for (int c = 0; c < 2; c++) begin
         tick();
         got = observed();
         checks++;
         if (got !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, got, 8'h00);
         end
      end
      reset  = 1'b0;
      inicio = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         got = observed();
         checks++;
         if (got !== 8'h00) begin
            failures++;
            $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, got, 8'h00);
         end
      end
   endtask

   task automatic test_msb_lsb();
      logic [7:0]   got, exp;
      logic [W-1:0] mv, lv;
      mv = '0;
      lv = '0;
      dado   = 8'h2D;
      inicio = 1'b1;
      for (int c = 0; c <= W + 1; c++) begin
         tick();
         inicio = 1'b0;
         dado   = W'($urandom);
         got = observed();
         exp = expected();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL msb_lsb cyc=%0d got=%b exp=%b", cyc, got, exp);
         end
         if (m_load === 1'b1) mv = {mv[W-2:0], m_saida};
         if (l_load === 1'b1) lv = {l_saida, lv[W-1:1]};
      end
      checks++;
      if (mv !== 8'h2D) begin
         failures++;
         $display("FAIL msb_word got=%h exp=%h", mv, 8'h2D);
      end
      checks++;
      if (lv !== 8'h2D) begin
         failures++;
         $display("FAIL lsb_rebuild got=%h exp=%h", lv, 8'h2D);
      end
   endtask

   task automatic test_ignored_start();
      logic [7:0] got, exp;
      dado   = 8'h2D;
      inicio = 1'b1;
      tick();
      for (int c = 1; c <= 16; c++) begin
         inicio = (c == 3);
         dado   = (c == 3) ? 8'hFF : W'($urandom);
         tick();
         got = observed();
         exp = expected();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL ignored_start cyc=%0d got=%b exp=%b", cyc, got, exp);
         end
      end
      inicio = 1'b0;
   endtask

   task automatic test_midword_reset();
      logic [7:0]   got, exp;
      logic [W-1:0] mv;
      dado   = 8'h2D;
      inicio = 1'b1;
      tick();
      inicio = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         reset = (c == 4);
         tick();
         got = observed();
         exp = expected();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL midword_reset cyc=%0d got=%b exp=%b", cyc, got, exp);
         end
         if (c >= 4) begin
            checks++;
            if (got !== 8'h00) begin
               failures++;
               $display("FAIL reset_drop cyc=%0d got=%b exp=%b", cyc, got, 8'h00);
            end
         end
      end
      reset  = 1'b0;
      mv     = '0;
      dado   = 8'hA5;
      inicio = 1'b1;
      for (int c = 0; c <= W + 1; c++) begin
         tick();
         inicio = 1'b0;
         got = observed();
         exp = expected();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL restart_a5 cyc=%0d got=%b exp=%b", cyc, got, exp);
         end
         if (m_load === 1'b1) mv = {mv[W-2:0], m_saida};
      end
      checks++;
      if (mv !== 8'hA5) begin
         failures++;
         $display("FAIL a5_word got=%h exp=%h", mv, 8'hA5);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] got, exp;
      int         low_cycles;
      low_cycles = 0;
      dado   = 8'h2D;
      inicio = 1'b1;
      tick();
      dado = 8'hC3;
      for (int c = 1; c <= 19; c++) begin
         if (c >= 10) inicio = 1'b0;
         tick();
         got = observed();
         exp = expected();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, got, exp);
         end
         if (c <= 16 && m_load !== 1'b1) low_cycles++;
         if (c == 9) begin
            checks++;
            if ({m_saida, m_load, l_saida, l_load} !== 4'b1111) begin
               failures++;
               $display("FAIL second_first_bit got=%b exp=%b",
                        {m_saida, m_load, l_saida, l_load}, 4'b1111);
            end
         end
      end
      checks++;
      if (low_cycles != 1) begin
         failures++;
         $display("FAIL load_gap got=%0d exp=%0d", low_cycles, 1);
      end
   endtask

   task automatic test_random();
      logic [7:0] got, exp;
      for (int c = 0; c < 400; c++) begin
         reset  = ($urandom_range(0, 39) == 0);
         inicio = ($urandom_range(0, 3) == 0);
         dado   = W'($urandom);
         tick();
         got = observed();
         exp = expected();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL random cyc=%0d got=%b exp=%b", cyc, got, exp);
         end
      end
      reset  = 1'b0;
      inicio = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset  = 1'b1;
      inicio = 1'b0;
      dado   = '0;
      test_reset();
      test_msb_lsb();
      test_ignored_start();
      test_midword_reset();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
